// File: rtl/branch_cond_unit.sv
// Branch condition/target unit: resolves B/BR in decode, waits on pending flags.
// Optional saturating branch counters enabled with BRANCH_STATS_EN.
module branch_cond_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        br_valid,
  input  logic        br_type,
  input  logic [2:0]  ccc,
  input  logic [8:0]  imm9,
  input  logic [15:0] pc_plus2,
  input  logic [15:0] rs_val,
  input  logic        N_flag,
  input  logic        Z_flag,
  input  logic        V_flag,
  input  logic        flag_wr_pending,
  output logic        stall,
  output logic        redirect,
  output logic [15:0] redirect_pc,
  output logic        flush
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0] br_total_cnt,
  output logic [15:0] br_taken_cnt
`endif
);

  typedef struct packed {
    logic        br_type;
    logic [2:0]  ccc;
    logic [8:0]  imm9;
    logic [15:0] pc_plus2;
    logic [15:0] rs_val;
  } br_ops_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    REDIR
  } state_t;

  state_t      state_q;
  state_t      state_d;
  br_ops_t     cap_q;
  br_ops_t     in_ops;
  br_ops_t     ops;
  logic        cap_en;
  logic        eval;
  logic        taken;
  logic        stall_c;
  logic [15:0] b_off;
  logic [15:0] target;
  logic [15:0] tgt_q;

  function automatic logic cond_met(
    input logic [2:0] c,
    input logic       n,
    input logic       z,
    input logic       v
  );
    logic r;
    r = 1'b0;
    unique case (c)
      3'b000: r = ~z;
      3'b001: r = z;
      3'b010: r = ~z & ~n;
      3'b011: r = n;
      3'b100: r = z | ~n;
      3'b101: r = n | z;
      3'b110: r = v;
      3'b111: r = 1'b1;
    endcase
    return r;
  endfunction

  assign in_ops = '{
    br_type:  br_type,
    ccc:      ccc,
    imm9:     imm9,
    pc_plus2: pc_plus2,
    rs_val:   rs_val
  };

  // IDLE resolves the live decode operands; WAIT resolves the captured ones.
  always_comb begin
    state_d = state_q;
    cap_en  = 1'b0;
    eval    = 1'b0;
    stall_c = 1'b0;
    ops     = cap_q;
    unique case (state_q)
      IDLE: begin
        ops = in_ops;
        if (br_valid) begin
          if (flag_wr_pending) begin
            cap_en  = 1'b1;
            stall_c = 1'b1;
            state_d = WAIT;
          end else begin
            eval = 1'b1;
          end
        end
      end
      WAIT: begin
        if (flag_wr_pending) begin
          stall_c = 1'b1;
        end else begin
          eval    = 1'b1;
          state_d = IDLE;
        end
      end
      REDIR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    taken = eval & cond_met(ops.ccc, N_flag, Z_flag, V_flag);
    if (taken) begin
      state_d = REDIR;
    end
  end

  assign b_off  = {{6{ops.imm9[8]}}, ops.imm9, 1'b0};
  assign target = ops.br_type ? ops.rs_val
                              : ops.pc_plus2 + b_off;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q <= '0;
    end else if (cap_en) begin
      cap_q <= in_ops;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_q <= '0;
    end else if (taken) begin
      tgt_q <= target;
    end
  end

  // Gated so stall drops the moment reset asserts, even with br_valid high.
  assign stall       = stall_c & rst_n;
  assign redirect    = (state_q == REDIR);
  assign flush       = (state_q == REDIR);
  assign redirect_pc = tgt_q;

`ifdef BRANCH_STATS_EN
  logic [15:0] total_q;
  logic [15:0] taken_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q <= '0;
      taken_q <= '0;
    end else begin
      if (eval && total_q != 16'hFFFF) begin
        total_q <= total_q + 16'd1;
      end
      if (taken && taken_q != 16'hFFFF) begin
        taken_q <= taken_q + 16'd1;
      end
    end
  end

  assign br_total_cnt = total_q;
  assign br_taken_cnt = taken_q;
`endif

endmodule

// File: tb/tb_branch_cond_unit.sv
// Directed bench for branch_cond_unit: vector table plus WAIT/reset sequences.
// Counter checks run only when BRANCH_STATS_EN is defined.
module tb_branch_cond_unit;

  logic        clk;
  logic        rst_n;
  logic        br_valid;
  logic        br_type;
  logic [2:0]  ccc;
  logic [8:0]  imm9;
  logic [15:0] pc_plus2;
  logic [15:0] rs_val;
  logic        N_flag;
  logic        Z_flag;
  logic        V_flag;
  logic        flag_wr_pending;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        flush;
`ifdef BRANCH_STATS_EN
  logic [15:0] br_total_cnt;
  logic [15:0] br_taken_cnt;
`endif

  branch_cond_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .br_valid        (br_valid),
    .br_type         (br_type),
    .ccc             (ccc),
    .imm9            (imm9),
    .pc_plus2        (pc_plus2),
    .rs_val          (rs_val),
    .N_flag          (N_flag),
    .Z_flag          (Z_flag),
    .V_flag          (V_flag),
    .flag_wr_pending (flag_wr_pending),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .flush           (flush)
`ifdef BRANCH_STATS_EN
    ,
    .br_total_cnt    (br_total_cnt),
    .br_taken_cnt    (br_taken_cnt)
`endif
  );

  typedef struct packed {
    logic        br_type;
    logic [2:0]  ccc;
    logic [8:0]  imm9;
    logic [15:0] pc;
    logic [15:0] rs;
    logic        n;
    logic        z;
    logic        v;
    logic        taken;
    logic [15:0] tgt;
  } vec_t;

  vec_t        vecs [16];
  int          n_vec;
  int          n_err;
  logic [15:0] last_pc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required $finish earlier");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_br(input logic t, input logic [2:0] c,
                        input logic [8:0] im, input logic [15:0] pc,
                        input logic [15:0] rs);
    br_type  = t;
    ccc      = c;
    imm9     = im;
    pc_plus2 = pc;
    rs_val   = rs;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    set_br(v.br_type, v.ccc, v.imm9, v.pc, v.rs);
    N_flag          = v.n;
    Z_flag          = v.z;
    V_flag          = v.v;
    br_valid        = 1'b1;
    flag_wr_pending = 1'b0;
    #1;
    chk($sformatf("vec%0d stall", idx), {15'd0, stall}, 16'd0);
    @(posedge clk);
    #1;
    chk($sformatf("vec%0d redirect", idx), {15'd0, redirect},
        {15'd0, v.taken});
    chk($sformatf("vec%0d flush", idx), {15'd0, flush},
        {15'd0, v.taken});
    if (v.taken) last_pc = v.tgt;
    chk($sformatf("vec%0d redirect_pc", idx), redirect_pc, last_pc);
    @(negedge clk);
    br_valid = 1'b0;
    if (v.taken) begin
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d redir_end", idx), {15'd0, redirect}, 16'd0);
      @(negedge clk);
    end
  endtask

`ifdef BRANCH_STATS_EN
  task automatic stat_branch(input logic tk);
    set_br(1'b0, tk ? 3'b111 : 3'b110, 9'h001, 16'h0100, 16'h0);
    V_flag          = 1'b0;
    flag_wr_pending = 1'b0;
    br_valid        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (tk) begin
      // REDIR cycle: a taken-looking br_valid here must not count
      br_valid = 1'b1;
      set_br(1'b0, 3'b111, 9'h001, 16'h0200, 16'h0);
      @(posedge clk);
      @(negedge clk);
    end
    br_valid = 1'b0;
  endtask
`endif

  initial begin
    n_vec   = 0;
    n_err   = 0;
    last_pc = 16'h0000;
    //            typ  ccc     imm9    pc        rs        n     z     v     tk    tgt
    vecs[0]  = '{1'b0, 3'b001, 9'h004, 16'h0010, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0018};
    vecs[1]  = '{1'b0, 3'b010, 9'h004, 16'h0010, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
    vecs[2]  = '{1'b0, 3'b000, 9'h1F0, 16'h0100, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00E0};
    vecs[3]  = '{1'b0, 3'b000, 9'h010, 16'h0100, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
    vecs[4]  = '{1'b0, 3'b010, 9'h0FF, 16'h2000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h21FE};
    vecs[5]  = '{1'b1, 3'b011, 9'h000, 16'h0000, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234};
    vecs[6]  = '{1'b1, 3'b011, 9'h000, 16'h0000, 16'h4321, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};
    vecs[7]  = '{1'b0, 3'b100, 9'h003, 16'h0050, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[8]  = '{1'b0, 3'b100, 9'h100, 16'h0004, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFE04};
    vecs[9]  = '{1'b0, 3'b101, 9'h003, 16'h0050, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[10] = '{1'b1, 3'b101, 9'h000, 16'h0000, 16'hA5A5, 1'b0, 1'b1, 1'b0, 1'b1, 16'hA5A5};
    vecs[11] = '{1'b0, 3'b110, 9'h000, 16'h0040, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0040};
    vecs[12] = '{1'b0, 3'b110, 9'h005, 16'h0040, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
    vecs[13] = '{1'b0, 3'b111, 9'h1FF, 16'hFFFE, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFC};
    vecs[14] = '{1'b0, 3'b111, 9'h002, 16'hFFFE, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0002};
    vecs[15] = '{1'b1, 3'b111, 9'h1FF, 16'h1111, 16'hC0DE, 1'b0, 1'b0, 1'b0, 1'b1, 16'hC0DE};

    // Reset state, with br_valid and pending both high
    rst_n           = 1'b0;
    br_valid        = 1'b1;
    flag_wr_pending = 1'b1;
    N_flag          = 1'b0;
    Z_flag          = 1'b0;
    V_flag          = 1'b0;
    set_br(1'b0, 3'b111, 9'h0, 16'h0, 16'h0);
    #2;
    chk("rst stall", {15'd0, stall}, 16'd0);
    chk("rst redirect", {15'd0, redirect}, 16'd0);
    chk("rst flush", {15'd0, flush}, 16'd0);
    chk("rst redirect_pc", redirect_pc, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n           = 1'b1;
    br_valid        = 1'b0;
    flag_wr_pending = 1'b0;

    // First vector lands in the first cycle after reset release
    for (int i = 0; i < 16; i++) begin
      apply_vec(vecs[i], i);
    end

    // BR waits two cycles on pending; WAIT ignores new decode inputs
    set_br(1'b1, 3'b111, 9'h0, 16'h0, 16'hBEEF);
    Z_flag          = 1'b1;
    br_valid        = 1'b1;
    flag_wr_pending = 1'b1;
    #1;
    chk("wait stall c1", {15'd0, stall}, 16'd1);
    @(negedge clk);
    set_br(1'b0, 3'b000, 9'h010, 16'h3000, 16'h0000);
    #1;
    chk("wait stall c2", {15'd0, stall}, 16'd1);
    @(posedge clk);
    #1;
    chk("wait no redirect", {15'd0, redirect}, 16'd0);
    @(negedge clk);
    flag_wr_pending = 1'b0;
    #1;
    chk("wait eval stall", {15'd0, stall}, 16'd0);
    @(posedge clk);
    #1;
    chk("wait redirect", {15'd0, redirect}, 16'd1);
    chk("wait flush", {15'd0, flush}, 16'd1);
    chk("wait redirect_pc", redirect_pc, 16'hBEEF);
    last_pc = 16'hBEEF;
    @(negedge clk);
    set_br(1'b0, 3'b111, 9'h000, 16'h4444, 16'h0);
    br_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("redir ignore valid", {15'd0, redirect}, 16'd0);
    chk("redir hold pc", redirect_pc, 16'hBEEF);
    @(negedge clk);
    br_valid = 1'b0;

    // Captured ccc resolved against the flags present at evaluation
    set_br(1'b0, 3'b001, 9'h001, 16'h0300, 16'h0);
    Z_flag          = 1'b0;
    br_valid        = 1'b1;
    flag_wr_pending = 1'b1;
    @(negedge clk);
    br_valid        = 1'b0;
    flag_wr_pending = 1'b0;
    Z_flag          = 1'b1;
    pc_plus2        = 16'h7777;
    @(posedge clk);
    #1;
    chk("late flag redirect", {15'd0, redirect}, 16'd1);
    chk("late flag pc", redirect_pc, 16'h0302);
    @(negedge clk);
    @(negedge clk);
    set_br(1'b0, 3'b001, 9'h001, 16'h0500, 16'h0);
    br_valid        = 1'b1;
    flag_wr_pending = 1'b1;
    @(negedge clk);
    br_valid        = 1'b0;
    flag_wr_pending = 1'b0;
    Z_flag          = 1'b0;
    @(posedge clk);
    #1;
    chk("wait nt redirect", {15'd0, redirect}, 16'd0);
    chk("wait nt stall", {15'd0, stall}, 16'd0);
    chk("wait nt pc hold", redirect_pc, 16'h0302);
    @(negedge clk);

    // Reset while in WAIT abandons the branch
    set_br(1'b1, 3'b111, 9'h0, 16'h0, 16'h5555);
    br_valid        = 1'b1;
    flag_wr_pending = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("wait rst stall", {15'd0, stall}, 16'd0);
    chk("wait rst pc", redirect_pc, 16'h0000);
    @(negedge clk);
    rst_n           = 1'b1;
    br_valid        = 1'b0;
    flag_wr_pending = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post rst redirect %0d", k), {15'd0, redirect}, 16'd0);
    end
    @(negedge clk);

    // Reset while in REDIR kills the pulse at once
    set_br(1'b0, 3'b111, 9'h002, 16'h0600, 16'h0);
    br_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("redir pre rst", {15'd0, redirect}, 16'd1);
    @(negedge clk);
    br_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("redir rst redirect", {15'd0, redirect}, 16'd0);
    chk("redir rst flush", {15'd0, flush}, 16'd0);
    chk("redir rst pc", redirect_pc, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("redir post rst", {15'd0, redirect}, 16'd0);
    @(negedge clk);

`ifdef BRANCH_STATS_EN
    rst_n = 1'b0;
    #1;
    chk("cnt rst total", br_total_cnt, 16'd0);
    chk("cnt rst taken", br_taken_cnt, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stat_branch(1'b1);
    stat_branch(1'b0);
    stat_branch(1'b1);
    stat_branch(1'b0);
    stat_branch(1'b1);
    #1;
    chk("cnt total", br_total_cnt, 16'd5);
    chk("cnt taken", br_taken_cnt, 16'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_cond_unit.md
BRANCH_COND_UNIT -- requirements
Module: branch_cond_unit

Interface
REQ-001 The block SHALL have a single clock `clk` and an asynchronous, active-low reset `rst_n`.
REQ-002 Port `clk`, input, 1 bit: rising-edge system clock.
REQ-003 Port `rst_n`, input, 1 bit: asynchronous active-low reset.
REQ-004 Port `br_valid`, input, 1 bit: branch instruction present in decode this cycle.
REQ-005 Port `br_type`, input, 1 bit: branch kind; 0 = B (PC-relative), 1 = BR (register target).
REQ-006 Port `ccc`, input, 3 bits: condition code.
REQ-007 Port `imm9`, input, 9 bits: signed word offset for B.
REQ-008 Port `pc_plus2`, input, 16 bits: address of the branch + 2.
REQ-009 Port `rs_val`, input, 16 bits: target register value for BR.
REQ-010 Ports `N_flag`, `Z_flag`, `V_flag`, inputs, 1 bit each: registered ALU flags.
REQ-011 Port `flag_wr_pending`, input, 1 bit: an older in-flight instruction has not yet written the flags.
REQ-012 Port `stall`, output, 1 bit: hold fetch and decode.
REQ-013 Port `redirect`, output, 1 bit: one-cycle taken-branch pulse.
REQ-014 Port `redirect_pc`, output, 16 bits: branch target, valid while `redirect`=1.
REQ-015 Port `flush`, output, 1 bit: kill the wrong-path decode instruction.

Function
REQ-016 Conditions SHALL be: 000 NE (Z=0), 001 EQ (Z=1), 010 GT (Z=0 & N=0), 011 LT (N=1), 100 GTE (Z=1 | N=0), 101 LTE (N=1 | Z=1), 110 OVFL (V=1), 111 always taken.
REQ-017 For B, the target SHALL be pc_plus2 + (sign-extended imm9 << 1), computed modulo 2^16 with wrap-around and no error.
REQ-018 For BR, the target SHALL be rs_val.
REQ-019 The FSM SHALL have three states: IDLE, WAIT, REDIR.
REQ-020 In IDLE with br_valid=1 and flag_wr_pending=0, the block SHALL evaluate the condition on the current flags in the same cycle.
- Taken: go to REDIR.
- Not taken: stay in IDLE; no output asserts.
REQ-021 In IDLE with br_valid=1 and flag_wr_pending=1:
- Capture br_type, ccc, imm9, pc_plus2 and rs_val.
- Assert `stall` combinationally in that cycle.
- Go to WAIT.
REQ-022 In WAIT, `stall` SHALL remain 1 while flag_wr_pending=1.
REQ-023 In WAIT, in the first cycle flag_wr_pending=0:
- Deassert `stall`.
- Evaluate the captured operands against the current flags.
- Go to REDIR if taken, else to IDLE.
REQ-024 In REDIR:
- `redirect`=1 and `flush`=1 for exactly one cycle.
- `redirect_pc` comes from a register loaded at evaluation.
- Next state is unconditionally IDLE.
REQ-025 Latency SHALL be one cycle from the evaluation cycle to the `redirect` pulse.
REQ-026 br_valid SHALL be ignored in WAIT (operands already captured) and in REDIR (wrong-path instruction).
REQ-027 Inputs SHALL NOT change captured operands while in WAIT.
REQ-028 Outside REDIR, `redirect_pc` SHALL hold its last value.
REQ-029 Back-to-back branches SHALL be accepted:
- A not-taken branch in IDLE allows a new acceptance on the next cycle.
- A taken branch allows a new acceptance on the cycle after REDIR.

Reset
REQ-030 Asserting rst_n=0 SHALL immediately force:
- state = IDLE
- stall = redirect = flush = 0
- redirect_pc = 16'h0000
- all captured operands = 0
REQ-031 Reset during WAIT or REDIR SHALL abandon the pending branch; no redirect is issued after reset release.
REQ-032 The first cycle after reset release SHALL accept br_valid normally.

Configuration
REQ-033 With macro BRANCH_STATS_EN defined, the block SHALL add two outputs:
- `br_total_cnt`, 16 bits: increments on each evaluation.
- `br_taken_cnt`, 16 bits: increments on each taken evaluation.
REQ-034 Both counters SHALL saturate at 16'hFFFF and reset to 0.
REQ-035 Without BRANCH_STATS_EN, these ports and their registers SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-036 B, ccc=001, Z=1, pending=0, pc_plus2=16'h0010, imm9=9'h004 -> next cycle redirect=1, flush=1, redirect_pc=16'h0018; then redirect=0.
REQ-037 B, ccc=010, N=0, Z=1 -> not taken; redirect, flush and stall stay 0; state stays IDLE.
REQ-038 BR, ccc=111, rs_val=16'hBEEF, pending=1 for 2 cycles -> stall=1 for 2 cycles; then stall=0 with evaluation; next cycle redirect_pc=16'hBEEF.
REQ-039 B, pc_plus2=16'hFFFE, imm9=9'h1FF (-1), ccc=111 -> redirect_pc=16'hFFFC; B, pc_plus2=16'hFFFE, imm9=9'h002 -> redirect_pc=16'h0002 (wrap).
REQ-040 rst_n pulsed low during WAIT -> stall=0 immediately; no redirect after release even with pending=0.
REQ-041 With BRANCH_STATS_EN: 3 taken and 2 not-taken branches -> br_total_cnt=5, br_taken_cnt=3; br_valid during REDIR is not counted.
